// File: rtl/ax_loop_cycle_ctrl_if.sv
// Fetch-lane and configuration bundle between the fetch stage and the loop
// perforation controller. The master drives lanes/config; the slave returns the decision.
interface ax_loop_cycle_ctrl_if #(
    parameter int FETCH_WIDTH   = 2,
    parameter int ITER_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH = 6,
    parameter int COOL_WIDTH    = 6
);
    logic [FETCH_WIDTH-1:0]   fetchStageIsValid;
    logic [FETCH_WIDTH-1:0]   bufferHit;
    logic [FETCH_WIDTH-1:0]   axbltcycbtbHit;
    logic [FETCH_WIDTH-1:0]   brPredTaken;
    logic                     stall;
    logic                     flush;
    logic                     cfgEnable;
    logic [ITER_WIDTH-1:0]    cfgLimit;
    logic [TIMEOUT_WIDTH-1:0] cfgTimeout;
    logic [COOL_WIDTH-1:0]    cfgCooldown;
    logic [FETCH_WIDTH-1:0]   brDecidCycTaken;
    logic                     loopActive;
    logic [ITER_WIDTH-1:0]    iterCount;
    logic                     perforateEvent;

    modport master (
        output fetchStageIsValid, bufferHit, axbltcycbtbHit, brPredTaken,
        output stall, flush, cfgEnable, cfgLimit, cfgTimeout, cfgCooldown,
        input  brDecidCycTaken, loopActive, iterCount, perforateEvent
    );

    modport slave (
        input  fetchStageIsValid, bufferHit, axbltcycbtbHit, brPredTaken,
        input  stall, flush, cfgEnable, cfgLimit, cfgTimeout, cfgCooldown,
        output brDecidCycTaken, loopActive, iterCount, perforateEvent
    );
endinterface

// File: rtl/ax_loop_cycle_ctrl.sv
// Loop-perforation controller: counts loop back-edges and, once the configured
// limit is reached, forces the next back-edge not-taken so the loop exits early.
module ax_loop_cycle_ctrl #(
    parameter int FETCH_WIDTH   = 2,
    parameter int ITER_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH = 6,
    parameter int COOL_WIDTH    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    ax_loop_cycle_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COUNT, COOLDOWN} state_t;

    state_t                   state_q;
    logic [ITER_WIDTH-1:0]    iter_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic [COOL_WIDTH-1:0]    cool_q;
    logic                     perf_q;

    logic [FETCH_WIDTH-1:0]   be;
    logic [FETCH_WIDTH-1:0]   first_be;
    logic                     any_be;
    logic                     any_valid;
    logic                     ovr;
    logic [TIMEOUT_WIDTH-1:0] tmo_d;
    logic [ITER_WIDTH-1:0]    iter_d;

    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_be
        assign be[gi] = bus.fetchStageIsValid[gi] & bus.bufferHit[gi]
                      & bus.axbltcycbtbHit[gi] & bus.brPredTaken[gi];
    end

    // Isolate the lowest set bit: only the first back-edge lane is acted upon.
    assign first_be  = be & (~be + FETCH_WIDTH'(1));
    assign any_be    = |be;
    assign any_valid = |bus.fetchStageIsValid;

    // rst gates the override so the predictor direction passes through while resetting.
    assign ovr = (state_q == COUNT) & bus.cfgEnable & (bus.cfgLimit != '0) & any_be
               & (iter_q >= bus.cfgLimit) & ~bus.stall & ~bus.flush & ~rst;

    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_dec
        assign bus.brDecidCycTaken[gi] = bus.brPredTaken[gi] & ~(ovr & first_be[gi]);
    end

    assign tmo_d  = tmo_q + TIMEOUT_WIDTH'(1);
    assign iter_d = (iter_q == '1) ? iter_q : iter_q + ITER_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state_q <= IDLE;
            iter_q  <= '0;
            tmo_q   <= '0;
            cool_q  <= '0;
            perf_q  <= 1'b0;
        end else if (bus.stall) begin
            perf_q  <= 1'b0;
        end else begin
            perf_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q  <= '0;
                    cool_q <= '0;
                    if (any_be && bus.cfgEnable && (bus.cfgLimit != '0)) begin
                        state_q <= COUNT;
                        iter_q  <= ITER_WIDTH'(1);
                    end else begin
                        iter_q  <= '0;
                    end
                end
                COUNT: begin
                    if (!bus.cfgEnable) begin
                        state_q <= IDLE;
                        iter_q  <= '0;
                        tmo_q   <= '0;
                    end else if (ovr) begin
                        state_q <= COOLDOWN;
                        cool_q  <= bus.cfgCooldown;
                        iter_q  <= '0;
                        tmo_q   <= '0;
                        perf_q  <= 1'b1;
                    end else if (any_be) begin
                        iter_q  <= iter_d;
                        tmo_q   <= '0;
                    end else if (any_valid) begin
                        if (tmo_d >= bus.cfgTimeout) begin
                            state_q <= IDLE;
                            iter_q  <= '0;
                            tmo_q   <= '0;
                        end else begin
                            tmo_q   <= tmo_d;
                        end
                    end
                end
                COOLDOWN: begin
                    // Occupancy is max(cfgCooldown, 1) non-stall cycles; back-edges are ignored.
                    if (cool_q <= COOL_WIDTH'(1)) begin
                        state_q <= IDLE;
                        cool_q  <= '0;
                    end else begin
                        cool_q  <= cool_q - COOL_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.loopActive     = (state_q == COUNT);
    assign bus.iterCount      = iter_q;
    assign bus.perforateEvent = perf_q;
endmodule

// File: tb/tb_ax_loop_cycle_ctrl.sv
// Directed bench for the loop-perforation controller: drives lanes on the falling
// edge, checks the combinational decision before the rising edge and registers after it.
module tb_ax_loop_cycle_ctrl;
    localparam int FW = 2;
    localparam int IW = 8;
    localparam int TW = 6;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ax_loop_cycle_ctrl_if #(.FETCH_WIDTH(FW), .ITER_WIDTH(IW),
                            .TIMEOUT_WIDTH(TW), .COOL_WIDTH(CW)) bus ();

    ax_loop_cycle_ctrl #(.FETCH_WIDTH(FW), .ITER_WIDTH(IW),
                         .TIMEOUT_WIDTH(TW), .COOL_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=%0h", tag, got);
        end
    endtask

    // One fetch cycle: drive, check same-cycle decision, then advance past the edge.
    task automatic cyc(input logic [1:0] v, input logic [1:0] h, input logic [1:0] b,
                       input logic [1:0] p, input logic s, input logic f,
                       input logic [1:0] exp_dec, input string tag);
        @(negedge clk);
        bus.fetchStageIsValid = v;
        bus.bufferHit         = h;
        bus.axbltcycbtbHit    = b;
        bus.brPredTaken       = p;
        bus.stall             = s;
        bus.flush             = f;
        #1;
        check_val({tag, ".dec"}, 32'(bus.brDecidCycTaken), 32'(exp_dec));
        @(posedge clk);
        #1;
    endtask

    task automatic be0(input logic [1:0] exp_dec, input string tag);
        cyc(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, exp_dec, tag);
    endtask

    task automatic idle(input string tag);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, tag);
    endtask

    task automatic do_flush(input string tag);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, tag);
    endtask

    task automatic regs(input string tag, input logic la, input logic [IW-1:0] it, input logic pe);
        check_val({tag, ".active"}, 32'(bus.loopActive), 32'(la));
        check_val({tag, ".iter"},   32'(bus.iterCount),  32'(it));
        check_val({tag, ".perf"},   32'(bus.perforateEvent), 32'(pe));
    endtask

    initial begin
        logic [1:0] p;
        rst = 1'b1;
        bus.fetchStageIsValid = '0;
        bus.bufferHit = '0;
        bus.axbltcycbtbHit = '0;
        bus.brPredTaken = '0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.cfgEnable = 1'b1;
        bus.cfgLimit = 8'd3;
        bus.cfgTimeout = 6'd4;
        bus.cfgCooldown = 6'd2;

        cyc(2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b11, "rst0");
        cyc(2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b11, "rst1");
        regs("rst", 1'b0, 8'd0, 1'b0);
        rst = 1'b0;

        // Limit 3, cooldown 2: three counted back-edges, fourth is forced not-taken.
        be0(2'b01, "t1_be1"); regs("t1_be1", 1'b1, 8'd1, 1'b0);
        be0(2'b01, "t1_be2"); regs("t1_be2", 1'b1, 8'd2, 1'b0);
        be0(2'b01, "t1_be3"); regs("t1_be3", 1'b1, 8'd3, 1'b0);
        be0(2'b00, "t1_ovr"); regs("t1_ovr", 1'b0, 8'd0, 1'b1);
        be0(2'b01, "t1_cool1"); regs("t1_cool1", 1'b0, 8'd0, 1'b0);
        idle("t1_cool2");       regs("t1_cool2", 1'b0, 8'd0, 1'b0);
        be0(2'b01, "t1_restart"); regs("t1_restart", 1'b1, 8'd1, 1'b0);
        do_flush("t1_flush");   regs("t1_flush", 1'b0, 8'd0, 1'b0);

        // Stall with a back-edge present does not count.
        be0(2'b01, "t2_be1");
        be0(2'b01, "t2_be2"); regs("t2_be2", 1'b1, 8'd2, 1'b0);
        cyc(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, "t2_stall");
        regs("t2_stall", 1'b1, 8'd2, 1'b0);
        be0(2'b01, "t2_be3"); regs("t2_be3", 1'b1, 8'd3, 1'b0);
        do_flush("t2_flush");

        // Flush mid-loop discards progress.
        bus.cfgLimit = 8'd5;
        be0(2'b01, "t3_be1");
        be0(2'b01, "t3_be2");
        be0(2'b01, "t3_be3"); regs("t3_be3", 1'b1, 8'd3, 1'b0);
        cyc(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 2'b01, "t3_flush");
        regs("t3_flush", 1'b0, 8'd0, 1'b0);
        be0(2'b01, "t3_restart"); regs("t3_restart", 1'b1, 8'd1, 1'b0);
        do_flush("t3_end");

        // Timeout 4: a cycle with no valid lane does not advance the timeout.
        be0(2'b01, "t4_start");
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01, "t4_nobe");
            regs("t4_nobe", 1'b1, 8'd1, 1'b0);
        end
        idle("t4_empty"); regs("t4_empty", 1'b1, 8'd1, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01, "t4_last");
        regs("t4_timeout", 1'b0, 8'd0, 1'b0);

        // Both lanes back-edge at the limit: only lane 0 is forced.
        bus.cfgLimit = 8'd3;
        be0(2'b01, "t5_be1");
        be0(2'b01, "t5_be2");
        be0(2'b01, "t5_be3");
        cyc(2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10, "t5_both");
        regs("t5_both", 1'b0, 8'd0, 1'b1);
        idle("t5_c1");
        idle("t5_c2");

        // Limit 1, back-edge on lane 1 only; lane 0 predicted taken but not a back-edge.
        bus.cfgLimit = 8'd1;
        cyc(2'b10, 2'b10, 2'b10, 2'b11, 1'b0, 1'b0, 2'b11, "t5_l1a");
        regs("t5_l1a", 1'b1, 8'd1, 1'b0);
        cyc(2'b10, 2'b10, 2'b10, 2'b11, 1'b0, 1'b0, 2'b01, "t5_l1ovr");
        regs("t5_l1ovr", 1'b0, 8'd0, 1'b1);
        idle("t5_c3");
        idle("t5_c4");

        // At the limit: stall and flush each suppress the override.
        be0(2'b01, "t6_start"); regs("t6_start", 1'b1, 8'd1, 1'b0);
        cyc(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, "t6_stall");
        regs("t6_stall", 1'b1, 8'd1, 1'b0);
        cyc(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 2'b01, "t6_flush");
        regs("t6_flush", 1'b0, 8'd0, 1'b0);
        be0(2'b01, "t6_re"); regs("t6_re", 1'b1, 8'd1, 1'b0);
        bus.cfgEnable = 1'b0;
        idle("t6_dis"); regs("t6_dis", 1'b0, 8'd0, 1'b0);
        bus.cfgEnable = 1'b1;
        be0(2'b01, "t6_re2");
        rst = 1'b1;
        be0(2'b01, "t6_rst"); regs("t6_rst", 1'b0, 8'd0, 1'b0);
        rst = 1'b0;

        // Perforation disabled by limit 0, then by enable low.
        bus.cfgLimit = 8'd0;
        for (int i = 0; i < 300; i++) begin
            p = 2'($urandom_range(0, 3));
            cyc(2'b11, 2'b11, 2'b11, p, 1'b0, 1'b0, p, "t7_lim0");
        end
        regs("t7_lim0", 1'b0, 8'd0, 1'b0);
        bus.cfgLimit = 8'd3;
        bus.cfgEnable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            p = 2'($urandom_range(0, 3));
            cyc(2'b11, 2'b11, 2'b11, p, 1'b0, 1'b0, p, "t7_dis");
        end
        regs("t7_dis", 1'b0, 8'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
